// File: rtl/wb_stage.sv
// -----------------------------------------------------------------------------
// wb_stage -- writeback stage of the integer pipeline.
//
// Accepts one retiring instruction per valid/ready handshake, waits for the
// data-memory read response on loads, aligns and sign/zero-extends the loaded
// value and drives the register-file write port for exactly one cycle. A
// retired-instruction counter advances once per completed instruction.
//
// Ports
//   clock        in   system clock, rising edge
//   reset        in   synchronous active-high reset
//   flush        in   kill in-flight / incoming instruction
//   in_valid     in   upstream presents an instruction
//   in_ready     out  stage can accept this cycle
//   reg_we       in   instruction writes rd
//   reg_sel      in   writeback source (RES / MEM / PC+4)
//   load_sel     in   load width and extension
//   rd           in   destination register index
//   res          in   ALU / address result
//   pc_plus_4    in   link value
//   mem_rvalid   in   data-memory read data valid
//   mem_rdata    in   aligned 32-bit memory word
//   rf_we        out  register file write enable (one-cycle pulse)
//   rf_waddr     out  register file write index
//   rf_wdata     out  register file write data
//   retired      out  count of completed instructions
// -----------------------------------------------------------------------------

`ifndef WB_STAGE_DEFS
`define WB_STAGE_DEFS
`define REG_NO_WRITE  1'b0
`define REG_WRITE     1'b1
`define REG_RES       2'd0
`define REG_MEM       2'd1
`define REG_PC_PLUS_4 2'd2
`define LOAD_W        3'd0
`define LOAD_H        3'd1
`define LOAD_HU       3'd2
`define LOAD_B        3'd3
`define LOAD_BU       3'd4
`endif

module wb_stage #(
   parameter int XLEN     = 32,
   parameter int RETIRE_W = 32
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                flush,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic                reg_we,
   input  logic [1:0]          reg_sel,
   input  logic [2:0]          load_sel,
   input  logic [4:0]          rd,
   input  logic [XLEN-1:0]     res,
   input  logic [XLEN-1:0]     pc_plus_4,
   input  logic                mem_rvalid,
   input  logic [XLEN-1:0]     mem_rdata,
   output logic                rf_we,
   output logic [4:0]          rf_waddr,
   output logic [XLEN-1:0]     rf_wdata,
   output logic [RETIRE_W-1:0] retired
);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      WAIT_MEM = 2'd1,
      WRITE    = 2'd2
   } state_t;

   // Align and extend a load from the 32-bit memory word.
   // addr_lo[0] is deliberately ignored for halfwords (no misalign trap).
   function automatic logic [31:0] ext_load(input logic [2:0]  sel,
                                            input logic [1:0]  lo,
                                            input logic [31:0] word);
      logic [15:0] half;
      logic [7:0]  byte_v;
      logic [31:0] out_v;
      half = lo[1] ? word[31:16] : word[15:0];
      case (lo)
         2'd0:    byte_v = word[7:0];
         2'd1:    byte_v = word[15:8];
         2'd2:    byte_v = word[23:16];
         2'd3:    byte_v = word[31:24];
         default: byte_v = word[7:0];
      endcase
      case (sel)
         `LOAD_W:  out_v = word;
         `LOAD_H:  out_v = {{16{half[15]}}, half};
         `LOAD_HU: out_v = {16'h0000, half};
         `LOAD_B:  out_v = {{24{byte_v[7]}}, byte_v};
         `LOAD_BU: out_v = {24'h00_0000, byte_v};
         default:  out_v = word;
      endcase
      return out_v;
   endfunction

   // Writeback source mux; unknown codes fall back to the ALU result.
   function automatic logic [31:0] sel_wb(input logic [1:0]  sel,
                                          input logic [31:0] res_v,
                                          input logic [31:0] pc4_v,
                                          input logic [31:0] mem_v);
      logic [31:0] out_v;
      case (sel)
         `REG_RES:       out_v = res_v;
         `REG_PC_PLUS_4: out_v = pc4_v;
         `REG_MEM:       out_v = mem_v;
         default:        out_v = res_v;
      endcase
      return out_v;
   endfunction

   state_t                r_state;
   logic                  r_in_ready;
   logic                  r_rf_we;
   logic [4:0]            r_rf_waddr;
   logic [XLEN-1:0]       r_rf_wdata;
   logic [RETIRE_W-1:0]   r_retired;

   // Captured instruction fields
   logic                  r_reg_we;
   logic [1:0]            r_reg_sel;
   logic [2:0]            r_load_sel;
   logic [4:0]            r_rd;
   logic [XLEN-1:0]       r_res;
   logic [1:0]            r_addr_lo;
   logic [XLEN-1:0]       r_pc_plus_4;

   state_t                w_next_state;
   logic                  w_accept;
   logic                  w_we_next;
   logic [4:0]            w_waddr_next;
   logic [XLEN-1:0]       w_wdata_next;

   // Next-state and next write-port values.
   always_comb begin
      w_next_state = r_state;
      w_we_next    = 1'b0;
      w_waddr_next = r_rf_waddr;
      w_wdata_next = r_rf_wdata;
      // flush folded in here so every accept path honours it
      w_accept     = in_valid && r_in_ready && !flush;

      case (r_state)
         IDLE, WRITE: begin
            if (w_accept) begin
               if (reg_sel == `REG_MEM) begin
                  w_next_state = WAIT_MEM;
               end else begin
                  w_next_state = WRITE;
                  w_waddr_next = rd;
                  if ((reg_we == `REG_WRITE) && (rd != 5'd0)) begin
                     w_we_next    = 1'b1;
                     w_wdata_next = sel_wb(reg_sel, res, pc_plus_4, res);
                  end else begin
                     w_we_next    = 1'b0;
                  end
               end
            end else begin
               w_next_state = IDLE;
            end
         end
         WAIT_MEM: begin
            if (flush) begin
               // load discarded; a late mem_rvalid lands in IDLE and is ignored
               w_next_state = IDLE;
            end else if (mem_rvalid) begin
               w_next_state = WRITE;
               w_waddr_next = r_rd;
               if ((r_reg_we == `REG_WRITE) && (r_rd != 5'd0)) begin
                  w_we_next    = 1'b1;
                  w_wdata_next = sel_wb(r_reg_sel, r_res, r_pc_plus_4,
                                        ext_load(r_load_sel, r_addr_lo, mem_rdata));
               end else begin
                  w_we_next    = 1'b0;
               end
            end else begin
               w_next_state = WAIT_MEM;
            end
         end
         default: begin
            w_next_state = IDLE;
         end
      endcase
   end

   // State, registered outputs, retire counter and field capture.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_state     <= IDLE;
         r_in_ready  <= 1'b1;
         r_rf_we     <= 1'b0;
         r_rf_waddr  <= 5'd0;
         r_rf_wdata  <= '0;
         r_retired   <= '0;
         r_reg_we    <= 1'b0;
         r_reg_sel   <= 2'd0;
         r_load_sel  <= 3'd0;
         r_rd        <= 5'd0;
         r_res       <= '0;
         r_addr_lo   <= 2'd0;
         r_pc_plus_4 <= '0;
      end else begin
         r_state    <= w_next_state;
         r_in_ready <= (w_next_state != WAIT_MEM);
         r_rf_we    <= w_we_next;
         r_rf_waddr <= w_waddr_next;
         r_rf_wdata <= w_wdata_next;
         // counted on entry so the value is visible during the WRITE cycle
         if (w_next_state == WRITE) begin
            r_retired <= r_retired + {{(RETIRE_W-1){1'b0}}, 1'b1};
         end
         if (w_accept) begin
            r_reg_we    <= reg_we;
            r_reg_sel   <= reg_sel;
            r_load_sel  <= load_sel;
            r_rd        <= rd;
            r_res       <= res;
            r_addr_lo   <= res[1:0];
            r_pc_plus_4 <= pc_plus_4;
         end
      end
   end

   assign in_ready = r_in_ready;
   assign rf_we    = r_rf_we;
   assign rf_waddr = r_rf_waddr;
   assign rf_wdata = r_rf_wdata;
   assign retired  = r_retired;

endmodule

// File: tb/tb_wb_stage.sv
// -----------------------------------------------------------------------------
// tb_wb_stage -- directed self-checking bench for wb_stage.
// Built with RETIRE_W=4 so counter wrap is reachable in a few cycles.
// -----------------------------------------------------------------------------

`ifndef WB_STAGE_DEFS
`define WB_STAGE_DEFS
`define REG_NO_WRITE  1'b0
`define REG_WRITE     1'b1
`define REG_RES       2'd0
`define REG_MEM       2'd1
`define REG_PC_PLUS_4 2'd2
`define LOAD_W        3'd0
`define LOAD_H        3'd1
`define LOAD_HU       3'd2
`define LOAD_B        3'd3
`define LOAD_BU       3'd4
`endif

module tb_wb_stage;

   logic        clock;
   logic        reset;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic        reg_we;
   logic [1:0]  reg_sel;
   logic [2:0]  load_sel;
   logic [4:0]  rd;
   logic [31:0] res;
   logic [31:0] pc_plus_4;
   logic        mem_rvalid;
   logic [31:0] mem_rdata;
   logic        rf_we;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;
   logic [3:0]  retired;

   int          n_tests;
   int          n_fail;
   logic [3:0]  exp_ret;

   wb_stage #(.XLEN(32), .RETIRE_W(4)) dut (
      .clock      (clock),
      .reset      (reset),
      .flush      (flush),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .reg_we     (reg_we),
      .reg_sel    (reg_sel),
      .load_sel   (load_sel),
      .rd         (rd),
      .res        (res),
      .pc_plus_4  (pc_plus_4),
      .mem_rvalid (mem_rvalid),
      .mem_rdata  (mem_rdata),
      .rf_we      (rf_we),
      .rf_waddr   (rf_waddr),
      .rf_wdata   (rf_wdata),
      .retired    (retired)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got=%h expected=%h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_we"},    32'(rf_we),    32'd0);
      chk({tag, "_waddr"}, 32'(rf_waddr), 32'd0);
      chk({tag, "_wdata"}, rf_wdata,      32'd0);
      chk({tag, "_ret"},   32'(retired),  32'd0);
      chk({tag, "_rdy"},   32'(in_ready), 32'd1);
   endtask

   // One load: a stray mem_rvalid in the accept cycle must be ignored.
   task automatic do_load(input string tag, input logic [2:0] ls, input logic [31:0] addr,
                          input logic [4:0] dst, input logic [31:0] word, input int waits,
                          input logic [31:0] exp_data);
      in_valid   = 1'b1;
      reg_we     = `REG_WRITE;
      reg_sel    = `REG_MEM;
      load_sel   = ls;
      rd         = dst;
      res        = addr;
      mem_rvalid = 1'b1;
      mem_rdata  = 32'hDEAD_BEEF;
      step();
      in_valid   = 1'b0;
      mem_rvalid = 1'b0;
      res        = 32'h0;
      chk({tag, "_rdy_wait"}, 32'(in_ready), 32'd0);
      chk({tag, "_we_wait"},  32'(rf_we),    32'd0);
      for (int i = 0; i < waits; i++) begin
         step();
         chk({tag, "_rdy_wait"}, 32'(in_ready), 32'd0);
      end
      mem_rvalid = 1'b1;
      mem_rdata  = word;
      step();
      mem_rvalid = 1'b0;
      exp_ret++;
      chk({tag, "_we"},    32'(rf_we),    32'd1);
      chk({tag, "_waddr"}, 32'(rf_waddr), 32'(dst));
      chk({tag, "_wdata"}, rf_wdata,      exp_data);
      chk({tag, "_ret"},   32'(retired),  32'(exp_ret));
   endtask

   initial begin
      n_tests    = 0;
      n_fail     = 0;
      exp_ret    = 4'd0;
      reset      = 1'b1;
      flush      = 1'b0;
      in_valid   = 1'b0;
      reg_we     = 1'b0;
      reg_sel    = 2'd0;
      load_sel   = 3'd0;
      rd         = 5'd0;
      res        = 32'h0;
      pc_plus_4  = 32'h0;
      mem_rvalid = 1'b0;
      mem_rdata  = 32'h0;
      step();
      step();
      reset = 1'b0;
      chk_reset_vals("rst");

      // Simple OP
      in_valid = 1'b1; reg_we = `REG_WRITE; reg_sel = `REG_RES; rd = 5'd5; res = 32'h0000_1234;
      step();
      in_valid = 1'b0;
      exp_ret++;
      chk("op_we",    32'(rf_we),    32'd1);
      chk("op_waddr", 32'(rf_waddr), 32'd5);
      chk("op_wdata", rf_wdata,      32'h0000_1234);
      chk("op_ret",   32'(retired),  32'd1);
      chk("op_rdy",   32'(in_ready), 32'd1);
      step();
      chk("op_we_off",  32'(rf_we),    32'd0);
      chk("op_hold_a",  32'(rf_waddr), 32'd5);
      chk("op_hold_d",  rf_wdata,      32'h0000_1234);

      // Loads with alignment and extension
      do_load("lb",  `LOAD_B,  32'h0000_2001, 5'd7,  32'h1122_F344, 3, 32'hFFFF_FFF3);
      do_load("lbu", `LOAD_BU, 32'h0000_2001, 5'd8,  32'h1122_F344, 3, 32'h0000_00F3);
      do_load("lh2", `LOAD_H,  32'h0000_2002, 5'd9,  32'h1122_F344, 1, 32'h0000_1122);
      do_load("lhu", `LOAD_HU, 32'h0000_2000, 5'd10, 32'h1122_F344, 0, 32'h0000_F344);
      do_load("lh0", `LOAD_H,  32'h0000_2000, 5'd10, 32'h1122_F344, 2, 32'hFFFF_F344);
      do_load("lw",  `LOAD_W,  32'h0000_2003, 5'd11, 32'h1122_F344, 0, 32'h1122_F344);
      do_load("lb3", `LOAD_B,  32'h0000_2003, 5'd12, 32'h1122_F344, 0, 32'h0000_0011);

      // JAL then OP to x0 back-to-back
      in_valid = 1'b1; reg_we = `REG_WRITE; reg_sel = `REG_PC_PLUS_4; rd = 5'd1;
      pc_plus_4 = 32'h0000_0108; res = 32'h0000_0999;
      step();
      exp_ret++;
      chk("jal_we",    32'(rf_we),    32'd1);
      chk("jal_waddr", 32'(rf_waddr), 32'd1);
      chk("jal_wdata", rf_wdata,      32'h0000_0108);
      chk("jal_ret",   32'(retired),  32'(exp_ret));
      reg_sel = `REG_RES; rd = 5'd0; res = 32'h0000_0055;
      step();
      in_valid = 1'b0;
      exp_ret++;
      chk("x0_we",  32'(rf_we),   32'd0);
      chk("x0_ret", 32'(retired), 32'(exp_ret));

      // Store retires without writing
      in_valid = 1'b1; reg_we = `REG_NO_WRITE; reg_sel = `REG_RES; rd = 5'd3; res = 32'h77;
      step();
      in_valid = 1'b0;
      exp_ret++;
      chk("st_we",  32'(rf_we),   32'd0);
      chk("st_ret", 32'(retired), 32'(exp_ret));
      step();
      chk("st_idle_ret", 32'(retired), 32'(exp_ret));

      // Flush in IDLE blocks the accept
      in_valid = 1'b1; flush = 1'b1; reg_we = `REG_WRITE; rd = 5'd6; res = 32'h66;
      step();
      in_valid = 1'b0; flush = 1'b0;
      chk("fidle_we",  32'(rf_we),    32'd0);
      chk("fidle_ret", 32'(retired),  32'(exp_ret));
      chk("fidle_rdy", 32'(in_ready), 32'd1);

      // Flush during WRITE keeps this write, kills the next
      in_valid = 1'b1; reg_we = `REG_WRITE; reg_sel = `REG_RES; rd = 5'd4; res = 32'h0000_0ABC;
      step();
      exp_ret++;
      chk("fwr_we",    32'(rf_we),   32'd1);
      chk("fwr_wdata", rf_wdata,     32'h0000_0ABC);
      flush = 1'b1; rd = 5'd13; res = 32'h0000_0DDD;
      step();
      flush = 1'b0; in_valid = 1'b0;
      chk("fwr_we_next", 32'(rf_we),    32'd0);
      chk("fwr_ret",     32'(retired),  32'(exp_ret));
      chk("fwr_waddr",   32'(rf_waddr), 32'd4);

      // Flush during WAIT_MEM discards the load
      in_valid = 1'b1; reg_we = `REG_WRITE; reg_sel = `REG_MEM; load_sel = `LOAD_W;
      rd = 5'd9; res = 32'h0000_4000;
      step();
      in_valid = 1'b0;
      chk("fwm_rdy0", 32'(in_ready), 32'd0);
      step();
      flush = 1'b1;
      step();
      flush = 1'b0;
      chk("fwm_rdy",  32'(in_ready), 32'd1);
      chk("fwm_we",   32'(rf_we),    32'd0);
      mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_0001;
      step();
      mem_rvalid = 1'b0;
      chk("fwm_late_we",  32'(rf_we),    32'd0);
      chk("fwm_late_ret", 32'(retired),  32'(exp_ret));
      chk("fwm_late_rdy", 32'(in_ready), 32'd1);

      // Retire back-to-back stores up to all-ones, then wrap
      in_valid = 1'b1; reg_we = `REG_NO_WRITE; reg_sel = `REG_RES; rd = 5'd2;
      while (exp_ret != 4'hF) begin
         step();
         exp_ret++;
         chk("wrap_cnt", 32'(retired), 32'(exp_ret));
      end
      chk("wrap_ones", 32'(retired), 32'hF);
      step();
      in_valid = 1'b0;
      chk("wrap_zero", 32'(retired), 32'h0);

      // Reset during WAIT_MEM
      in_valid = 1'b1; reg_we = `REG_WRITE; reg_sel = `REG_MEM; load_sel = `LOAD_W;
      rd = 5'd17; res = 32'h0000_5000;
      step();
      in_valid = 1'b0;
      chk("rwm_rdy0", 32'(in_ready), 32'd0);
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk_reset_vals("rwm");
      mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678;
      step();
      mem_rvalid = 1'b0;
      chk("rwm_late_we",  32'(rf_we),   32'd0);
      chk("rwm_late_ret", 32'(retired), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Writeback stage, directly downstream of the writeback decoder.
- Accepts one retiring instruction per handshake: its control fields (reg_we, reg_sel, load_sel) and its data (ALU result, PC+4, load data from data memory).
- Waits for the data-memory read response on loads, then aligns and extends it and drives the register file write port.
- Also keeps a retired-instruction counter.

Parameters:
- XLEN, 32, datapath width (only 32 is supported).
- RETIRE_W, 32, width of the retired-instruction counter.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  kill the in-flight/incoming instruction, no write.
- in_valid  in  1  upstream presents an instruction.
- in_ready  out  1  stage can accept this cycle.
- reg_we  in  1  instruction writes rd (`REG_WRITE / `REG_NO_WRITE).
- reg_sel  in  2  write source: `REG_RES, `REG_MEM, `REG_PC_PLUS_4.
- load_sel  in  3  `LOAD_W, `LOAD_H, `LOAD_HU, `LOAD_B, `LOAD_BU.
- rd  in  5  destination register index.
- res  in  XLEN  ALU/address result.
- pc_plus_4  in  XLEN  link value.
- mem_rvalid  in  1  data-memory read data valid.
- mem_rdata  in  XLEN  aligned 32-bit word read from memory.
- rf_we  out  1  register file write enable (one-cycle pulse).
- rf_waddr  out  5  register file write index.
- rf_wdata  out  XLEN  register file write data.
- retired  out  RETIRE_W  count of completed instructions.

Behaviour:
- Reset values:
  - State is IDLE.
  - rf_we=0, rf_waddr=0, rf_wdata=0, retired=0, in_ready=1.
  - All captured fields are 0.
- Accept rule: an instruction is accepted on a rising edge where in_valid && in_ready && !flush. On accept, capture reg_we, reg_sel, load_sel, rd, res, res[1:0] (as addr_lo), and pc_plus_4.
- States:
  - IDLE: in_ready=1.
    - Accept of a load (reg_sel==`REG_MEM) -> WAIT_MEM.
    - Accept of anything else -> WRITE.
    - No accept -> stay in IDLE.
  - WAIT_MEM: in_ready=0.
    - mem_rvalid is sampled only in this state. A mem_rvalid seen in the accept cycle is ignored.
    - mem_rvalid=1 -> capture extended data, go to WRITE.
    - mem_rvalid=0 -> stay in WAIT_MEM, with no timeout.
  - WRITE: outputs are driven for exactly this cycle, and in_ready=1 (back-to-back supported).
    - Accept -> WAIT_MEM or WRITE, by the same rule as IDLE.
    - No accept -> IDLE.
- Write outputs:
  - rf_we=1 only in WRITE, and only when captured reg_we==`REG_WRITE and rd!=0 (x0 is never written).
  - rf_waddr=rd is valid in WRITE and held otherwise.
  - rf_wdata is held between writes.
- Latency:
  - Non-load: accept at edge N -> rf_we high during cycle N..N+1 (one cycle after accept).
  - Load: mem_rvalid sampled at edge M -> rf_we high the following cycle.
- Data select:
  - `REG_RES -> res.
  - `REG_PC_PLUS_4 -> pc_plus_4.
  - `REG_MEM -> extended load data.
  - Undefined reg_sel code -> res.
- Load extension:
  - `LOAD_W: the full word; addr_lo is ignored.
  - `LOAD_H / `LOAD_HU: halfword mem_rdata[16*addr_lo[1] +: 16], sign-extended / zero-extended.
  - `LOAD_B / `LOAD_BU: byte mem_rdata[8*addr_lo +: 8], sign-extended / zero-extended.
  - Undefined load_sel -> word.
  - Misaligned accesses are not trapped; addr_lo[0] is ignored for halfwords.
- Retire counter:
  - Increments by 1 in every WRITE cycle, whether or not rf_we is asserted (stores and branches also retire).
  - Wraps modulo 2^RETIRE_W.
- Flush has priority over everything except reset:
  - Next state IDLE, no accept, no write next cycle, retired not incremented for the killed instruction.
  - Flush asserted during WRITE does not cancel that cycle's write (already committed).
  - Flush during WAIT_MEM discards the load; a mem_rvalid arriving later in IDLE is ignored.
- Reset mid-operation: reset in any state -> reset values at the next edge, and a pending load is discarded.

Test Plan:
- Reset released, accept OP with res=0x0000_1234, rd=5, reg_sel=`REG_RES -> the next cycle has rf_we=1, rf_waddr=5, rf_wdata=0x0000_1234, retired=1.
- LOAD `LOAD_B, res=0x...01, mem_rdata=0x1122_F344 given after 3 wait cycles -> in_ready=0 for those cycles. The cycle after mem_rvalid has rf_wdata=0xFFFF_FFF3. Repeating with `LOAD_BU gives 0x0000_00F3, and `LOAD_H with addr_lo=2 gives 0x0000_1122.
- JAL with pc_plus_4=0x0000_0108, rd=1 accepted back-to-back with OP rd=0 -> rf_we pulses once (rd=1, 0x108). The rd=0 instruction gives no write, retired=2.
- Store (reg_we=`REG_NO_WRITE) accepted -> rf_we stays 0, retired increments by 1.
- Load pending in WAIT_MEM, flush=1 for one cycle, then mem_rvalid=1 -> no rf_we, state IDLE, retired unchanged, in_ready=1.
- Preload retired to all-ones by retiring 2^RETIRE_W-1 instructions (RETIRE_W=4 build) -> the next retire wraps it to 0. Reset asserted during WAIT_MEM -> all outputs return to reset values at the next edge.
